// File: rtl/fm_param_loader.sv
// Byte-stream configuration loader for the FM generator: frames land in shadow registers,
// and a commit moves them to the active outputs atomically. Optional macro: FM_LOADER_TIMEOUT_EN.
module fm_param_loader #(
  parameter int sine_lookup_width = 16,
  parameter int accumulator_width = 32,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_ce,
  input  logic [7:0]                   i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [accumulator_width-2:0] o_carrier_center_increment,
  output logic [accumulator_width-2:0] o_modulation_increment,
  output logic [sine_lookup_width:0]   o_modulation_deviation_amount,
  output logic                         o_update,
  output logic                         o_error,
  output logic [1:0]                   o_state
);

  localparam int IW = accumulator_width - 1;
  localparam int DW = sine_lookup_width + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  // Handshake: a byte transfers on a rising edge where i_valid && o_ready; the
  // source must hold i_data stable while i_valid is high and o_ready is low.

  state_t          r_state, w_next;
  logic [1:0]      r_target;
  logic [1:0]      r_cnt;
  logic [31:0]     r_asm;
  logic [IW-1:0]   r_sh_car, r_sh_mod, r_act_car, r_act_mod;
  logic [DW-1:0]   r_sh_dev, r_act_dev;
  logic            r_error;
  logic            w_accept, w_err_set, w_load_active, w_frame_done;
  logic [31:0]     w_assembled;

  assign o_ready     = (r_state != S_COMMIT);
  assign w_accept    = i_valid && o_ready;
  assign w_assembled = {r_asm[23:0], i_data};

`ifdef FM_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_to_cnt;
  logic          w_timeout;
  assign w_timeout = (r_state == S_DATA) && !w_accept && (r_to_cnt == TO_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                         r_to_cnt <= '0;
    else if (r_state != S_DATA || w_accept) r_to_cnt <= '0;
    else                                 r_to_cnt <= r_to_cnt + 1'b1;
  end
`endif

  always_comb begin
    w_next        = r_state;
    w_err_set     = 1'b0;
    w_load_active = 1'b0;
    w_frame_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (i_data)
            8'h01, 8'h02, 8'h03: w_next = S_DATA;
            8'h04: begin
              w_next        = S_COMMIT;
              w_load_active = 1'b1;
            end
            default: w_err_set = 1'b1;
          endcase
        end
      end
      S_DATA: begin
        if (w_accept && r_cnt == 2'd3) begin
          w_frame_done = 1'b1;
          w_next       = S_IDLE;
        end
`ifdef FM_LOADER_TIMEOUT_EN
        else if (w_timeout) begin
          w_err_set = 1'b1;
          w_next    = S_IDLE;
        end
`endif
      end
      S_COMMIT: if (i_ce) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_error   <= 1'b0;
      r_target  <= 2'd0;
      r_cnt     <= 2'd0;
      r_asm     <= '0;
      r_sh_car  <= '0;
      r_sh_mod  <= '0;
      r_sh_dev  <= '0;
      r_act_car <= '0;
      r_act_mod <= '0;
      r_act_dev <= '0;
    end else begin
      r_state <= w_next;
      r_error <= w_err_set;
      if (r_state == S_IDLE && w_accept) begin
        r_target <= i_data[1:0];
        r_cnt    <= 2'd0;
        r_asm    <= '0;
      end
      if (r_state == S_DATA && w_accept) begin
        r_asm <= w_assembled;
        r_cnt <= r_cnt + 2'd1;
      end
      // Values are stored bit-exact, keeping only the low bits that fit.
      if (w_frame_done) begin
        case (r_target)
          2'd1:    r_sh_car <= w_assembled[IW-1:0];
          2'd2:    r_sh_mod <= w_assembled[IW-1:0];
          default: r_sh_dev <= w_assembled[DW-1:0];
        endcase
      end
      if (w_load_active) begin
        r_act_car <= r_sh_car;
        r_act_mod <= r_sh_mod;
        r_act_dev <= r_sh_dev;
      end
    end
  end

  assign o_update                      = (r_state == S_COMMIT) && i_ce;
  assign o_error                       = r_error;
  assign o_carrier_center_increment    = r_act_car;
  assign o_modulation_increment        = r_act_mod;
  assign o_modulation_deviation_amount = r_act_dev;
  assign o_state                       = r_state;

endmodule

// File: tb/tb_fm_param_loader.sv
// Scoreboard bench for fm_param_loader: a shadow/active model predicts each committed set,
// and a negedge monitor checks every update pulse, output stability and error pulses.
module tb_fm_param_loader;
  localparam int IW = 31;
  localparam int DW = 17;
  localparam int AT = 2 * IW + DW;

  logic          clk, rst, ce, valid, ready, upd, err;
  logic [7:0]    data;
  logic [IW-1:0] car, mod;
  logic [DW-1:0] dev;
  logic [1:0]    st;

  logic [AT-1:0] exp_q[$];
  logic [IW-1:0] sh_c, sh_m, cur_c, cur_m;
  logic [DW-1:0] sh_d, cur_d;
  int checks = 0, errors = 0, err_seen = 0, err_exp = 0, ce_mode = 1;
  logic prev_upd = 1'b0;

  fm_param_loader #(.sine_lookup_width(16), .accumulator_width(32), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_data(data), .i_valid(valid), .o_ready(ready),
    .o_carrier_center_increment(car), .o_modulation_increment(mod),
    .o_modulation_deviation_amount(dev), .o_update(upd), .o_error(err), .o_state(st)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ce: 0 random, 1 every 4th clock, 2 held low, 3 held high
  initial begin
    int ph = 0;
    ce = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ce_mode)
        0: ce = ($urandom_range(0, 3) == 0);
        1: begin ce = (ph == 3); ph = (ph + 1) % 4; end
        2: ce = 1'b0;
        default: ce = 1'b1;
      endcase
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // driver tasks; callers are aligned just after a rising edge
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    logic r;
    valid = 1'b1;
    data  = b;
    forever begin
      @(negedge clk);
      r = ready;
      @(posedge clk);
      if (r) break;
      n++;
      if (n > 300) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    #1 valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] v);
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) begin
      cyc($urandom_range(0, 2));
      send_byte(v[i*8 +: 8]);
    end
    case (cmd)
      8'h01:   sh_c = v[IW-1:0];
      8'h02:   sh_m = v[IW-1:0];
      default: sh_d = v[DW-1:0];
    endcase
  endtask

  task automatic commit();
    exp_q.push_back({sh_c, sh_m, sh_d});
    send_byte(8'h04);
  endtask

  task automatic bad_byte(input logic [7:0] b);
    err_exp++;
    send_byte(b);
    cyc(2);
    chk("error_pulse_count", 96'(err_seen), 96'(err_exp));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      cyc(1);
      n++;
    end
    chk("drain_queue_empty", 96'(exp_q.size()), 96'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    sh_c = '0; sh_m = '0; sh_d = '0;
    cur_c = '0; cur_m = '0; cur_d = '0;
    prev_upd = 1'b0;
    #3;
    chk("reset_actives", {car, mod, dev}, '0);
    chk("reset_ready", ready, 1);
    chk("reset_update", upd, 0);
    chk("reset_error", err, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (upd) begin
        logic [AT-1:0] e;
        chk("update_with_ce", ce, 1);
        chk("update_not_error", err, 0);
        chk("update_single_cycle", prev_upd, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_update", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("carrier", car, e[AT-1 -: IW]);
          chk("modulation", mod, e[DW +: IW]);
          chk("deviation", dev, e[DW-1:0]);
          cur_c = e[AT-1 -: IW];
          cur_m = e[DW +: IW];
          cur_d = e[DW-1:0];
        end
      end else if (ready) begin
        chk("active_stable", {car, mod, dev}, {cur_c, cur_m, cur_d});
      end
      if (err) err_seen++;
      prev_upd = upd;
    end
  end

  initial begin
    rst = 1'b1; valid = 1'b0; data = 8'h00;
    sh_c = '0; sh_m = '0; sh_d = '0;
    cur_c = '0; cur_m = '0; cur_d = '0;
    repeat (3) @(posedge clk);
    #3;
    chk("por_actives", {car, mod, dev}, '0);
    chk("por_ready", ready, 1);
    chk("por_update_error", {upd, err}, 0);
    rst = 1'b0;
    cyc(1);

    // carrier write and commit, ce every 4th clock
    send_frame(8'h01, 32'h0012_3456);
    commit();
    drain();

    // truncation
    send_frame(8'h02, 32'hFFFF_FFFF);
    send_frame(8'h03, 32'h0001_FFFF);
    commit();
    drain();

    // atomicity, then commits without writes
    send_frame(8'h01, 32'h0000_0100);
    commit();
    drain();
    send_frame(8'h01, 32'h0000_0200);
    cyc(6);
    commit();
    drain();
    commit();
    commit();
    drain();

    // backpressure: commit with ce held low while the next byte waits
    ce_mode = 2;
    commit();
    valid = 1'b1;
    data  = 8'h01;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ready_low", ready, 0);
      chk("bp_no_update", upd, 0);
      @(posedge clk); #1;
    end
    ce_mode = 3;
    send_byte(8'h01);
    chk("bp_update_seen", 96'(exp_q.size()), 96'd0);
    for (int i = 3; i >= 0; i--) begin
      logic [31:0] v = 32'h00AB_CDEF;
      send_byte(v[i*8 +: 8]);
    end
    sh_c = 31'h00AB_CDEF;
    ce_mode = 0;
    commit();
    drain();

    // unknown command bytes
    bad_byte(8'h7E);
    bad_byte(8'h00);
    bad_byte(8'h05);

    // reset mid-frame
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset();
    send_frame(8'h02, 32'h1357_9BDF);
    commit();
    drain();

    // reset inside the commit wait: no update may follow
    ce_mode = 2;
    send_frame(8'h01, 32'h0000_0055);
    commit();
    cyc(3);
    do_reset();
    ce_mode = 0;
    cyc(8);

`ifdef FM_LOADER_TIMEOUT_EN
    send_byte(8'h03);
    send_byte(8'h01);
    err_exp++;
    cyc(20);
    chk("timeout_error", 96'(err_seen), 96'(err_exp));
    send_frame(8'h03, 32'h0000_0007);
    commit();
    drain();
`endif

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0: send_frame(8'h01, $urandom);
        1: send_frame(8'h02, $urandom);
        2: send_frame(8'h03, $urandom);
        3: commit();
        4: bad_byte(8'(8'h05 + $urandom_range(0, 250)));
        default: cyc($urandom_range(1, 5));
      endcase
    end
    commit();
    drain();
    cyc(3);
    chk("final_error_count", 96'(err_seen), 96'(err_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
